cva6_lsu_mem_arbiter: RTL and testbench

CVA6_LSU_MEM_ARBITER -- requirements
Module: cva6_lsu_mem_arbiter

---
 rtl/cva6_lsu_arb_pkg.sv | 20 ++
 rtl/cva6_lsu_starve_ctr.sv | 38 +++
 rtl/cva6_lsu_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_cva6_lsu_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_lsu_arb_pkg.sv
// Shared types and defaults for the LSU single-port memory arbiter.
package cva6_lsu_arb_pkg;

    // Default number of consecutive load wins tolerated while a store waits.
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    // Arbiter FSM: one transaction in flight at most.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    // Which requester owns the outstanding transaction.
    typedef enum logic {
        OWN_LOAD  = 1'b0,
        OWN_STORE = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/cva6_lsu_starve_ctr.sv
// Saturating 4-bit counter of load wins taken while a store is waiting.
module cva6_lsu_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [3:0] LIMIT_C = 4'(LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Clear has priority; increment stops once the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/cva6_lsu_mem_arbiter.sv
// Arbitrates LSU loads and committed-store drains onto one memory port,
// with a starvation guard so a pending store is eventually served.
module cva6_lsu_mem_arbiter
    import cva6_lsu_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned ADDR_W       = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_req_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              store_req_i,
    input  logic [ADDR_W-1:0] store_addr_i,
    input  logic              store_hazard_i,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              load_resp_o,
    output logic              store_resp_o,
    output logic              busy_o,
    output logic              err_o
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load_resp_q, load_resp_d;
    logic              store_resp_q, store_resp_d;
    logic              err_q, err_d;

    logic starve_inc;
    logic starve_clr;
    logic starve_at_limit;
    logic store_win;
    logic load_win;

    cva6_lsu_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (starve_inc),
        .clr_i      (starve_clr),
        .at_limit_o (starve_at_limit)
    );

    // Store goes first on an alias hazard, once loads have starved it long
    // enough, or when it is the only requester.
    assign store_win = store_req_i &&
                       (store_hazard_i || starve_at_limit || !load_req_i);
    assign load_win  = load_req_i && !store_win;

    // Next-state, latch and error logic; owner requests only matter in IDLE,
    // so they are naturally ignored while a transaction is in flight.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        err_d        = err_q;
        load_resp_d  = 1'b0;
        store_resp_d = 1'b0;
        starve_inc   = 1'b0;
        starve_clr   = 1'b0;

        // Protocol violations are recorded but never move the FSM.
        if (mem_rvalid_i && (state_q != ST_WAIT)) begin
            err_d = 1'b1;
        end
        if (mem_gnt_i && (state_q != ST_REQ)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (store_win) begin
                    state_d    = ST_REQ;
                    owner_d    = OWN_STORE;
                    we_d       = 1'b1;
                    addr_d     = store_addr_i;
                    starve_clr = 1'b1;
                end else if (load_win) begin
                    state_d    = ST_REQ;
                    owner_d    = OWN_LOAD;
                    we_d       = 1'b0;
                    addr_d     = load_addr_i;
                    starve_inc = store_req_i;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_STORE) begin
                        store_resp_d = 1'b1;
                    end else begin
                        load_resp_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-output registers; reset drops any transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_LOAD;
            we_q         <= 1'b0;
            addr_q       <= '0;
            load_resp_q  <= 1'b0;
            store_resp_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            load_resp_q  <= load_resp_d;
            store_resp_q <= store_resp_d;
            err_q        <= err_d;
        end
    end

    assign mem_req_o    = (state_q == ST_REQ);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign load_resp_o  = load_resp_q;
    assign store_resp_o = store_resp_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_cva6_lsu_mem_arbiter.sv
// Bench for the LSU memory arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a behavioural model.
module tb_cva6_lsu_mem_arbiter;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_req = 1'b0;
    logic [8:0] load_addr = '0;
    logic       store_req = 1'b0;
    logic [8:0] store_addr = '0;
    logic       hazard = 1'b0;
    logic       gnt = 1'b0;
    logic       rvalid = 1'b0;
    logic       mem_req_o, mem_we_o, load_resp_o, store_resp_o, busy_o, err_o;
    logic [8:0] mem_addr_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: phase 0 = no transaction, 1 = request offered, 2 = awaiting data.
    int         m_phase = 0;
    bit         m_store_own = 0;
    bit         m_we = 0;
    logic [8:0] m_addr = '0;
    int         m_starve = 0;
    bit         m_rl = 0, m_rs = 0, m_err = 0;

    cva6_lsu_mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(9)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .load_req_i     (load_req),
        .load_addr_i    (load_addr),
        .store_req_i    (store_req),
        .store_addr_i   (store_addr),
        .store_hazard_i (hazard),
        .mem_gnt_i      (gnt),
        .mem_rvalid_i   (rvalid),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .load_resp_o    (load_resp_o),
        .store_resp_o   (store_resp_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Who the priority rule picks: 0 nobody, 1 load, 2 store.
    function automatic int pick(input bit l, input bit s, input bit h, input int starve);
        if (s && (h || starve == LIMIT || !l)) return 2;
        if (l) return 1;
        return 0;
    endfunction

    // Advance the model by one edge using the inputs the DUT just sampled.
    task automatic model_update();
        bit nrl = 0, nrs = 0;
        int w;
        if (rst) begin
            m_phase = 0; m_store_own = 0; m_we = 0; m_addr = '0;
            m_starve = 0; m_rl = 0; m_rs = 0; m_err = 0;
            return;
        end
        if (rvalid && m_phase != 2) m_err = 1;
        if (gnt && m_phase != 1) m_err = 1;
        if (m_phase == 0) begin
            w = pick(load_req, store_req, hazard, m_starve);
            if (w == 2) begin
                m_phase = 1; m_store_own = 1; m_we = 1; m_addr = store_addr; m_starve = 0;
            end else if (w == 1) begin
                m_phase = 1; m_store_own = 0; m_we = 0; m_addr = load_addr;
                if (store_req) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            end
        end else if (m_phase == 1) begin
            if (gnt) m_phase = 2;
        end else begin
            if (rvalid) begin
                m_phase = 0;
                if (m_store_own) nrs = 1; else nrl = 1;
            end
        end
        m_rl = nrl;
        m_rs = nrs;
    endtask

    task automatic compare_all();
        check_val("mem_req", mem_req_o, int'(m_phase == 1));
        check_val("busy", busy_o, int'(m_phase != 0));
        check_val("mem_we", mem_we_o, m_we);
        check_val("mem_addr", mem_addr_o, m_addr);
        check_val("load_resp", load_resp_o, m_rl);
        check_val("store_resp", store_resp_o, m_rs);
        check_val("err", err_o, m_err);
    endtask

    // One clock: sample just after the edge, update model, compare.
    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_req"}, mem_req_o, 0);
        check_val({tag, "_we"}, mem_we_o, 0);
        check_val({tag, "_addr"}, mem_addr_o, 0);
        check_val({tag, "_lresp"}, load_resp_o, 0);
        check_val({tag, "_sresp"}, store_resp_o, 0);
        check_val({tag, "_busy"}, busy_o, 0);
        check_val({tag, "_err"}, err_o, 0);
    endtask

    task automatic do_reset();
        rst = 1; load_req = 0; store_req = 0; hazard = 0; gnt = 0; rvalid = 0;
        #1;
        check_zero("rst");
        step();
        step();
        rst = 0;
    endtask

    // Wait for the request phase, grant after gd cycles, complete after rd.
    // Returns in the response-pulse cycle.
    task automatic serve(input int gd, input int rd, output logic we_seen);
        int guard = 0;
        while (m_phase != 1 && guard < 20) begin
            step();
            guard++;
        end
        check_val("serve_timeout", int'(guard >= 20), 0);
        we_seen = mem_we_o;
        repeat (gd) step();
        gnt = 1; step(); gnt = 0;
        repeat (rd) step();
        rvalid = 1; step(); rvalid = 0;
    endtask

    task automatic rand_cycle(input bit allow_err);
        if (m_rl) begin
            if ($urandom_range(0, 1) == 0) load_req = 0;
            else load_addr = 9'($urandom);
        end else if (!load_req && $urandom_range(0, 2) == 0) begin
            load_req = 1; load_addr = 9'($urandom);
        end
        if (m_rs) begin
            if ($urandom_range(0, 1) == 0) store_req = 0;
            else store_addr = 9'($urandom);
        end else if (!store_req && $urandom_range(0, 2) == 0) begin
            store_req = 1; store_addr = 9'($urandom);
        end
        hazard = load_req && store_req && ($urandom_range(0, 3) == 0);
        gnt    = (m_phase == 1) && ($urandom_range(0, 2) == 0);
        rvalid = (m_phase == 2) && ($urandom_range(0, 2) == 0);
        if (allow_err) begin
            if ($urandom_range(0, 19) == 0) gnt = 1;
            if ($urandom_range(0, 19) == 0) rvalid = 1;
        end
        step();
    endtask

    initial begin
        logic we_seen;

        // Single load, address 0x1A, exact cycle timing.
        do_reset();
        load_req = 1; load_addr = 9'h01A;          // cycle 1
        step();                                      // cycle 2
        check_val("c032_req_c2", mem_req_o, 1);
        check_val("c032_we", mem_we_o, 0);
        check_val("c032_addr", mem_addr_o, 9'h01A);
        step();                                      // cycle 3
        gnt = 1;
        step();                                      // cycle 4
        gnt = 0;
        check_val("c032_req_c4", mem_req_o, 0);
        check_val("c032_busy_c4", busy_o, 1);
        step();                                      // cycle 5
        rvalid = 1;
        step();                                      // cycle 6
        rvalid = 0;
        check_val("c032_lresp_c6", load_resp_o, 1);
        load_req = 0;
        step();                                      // cycle 7
        check_val("c032_lresp_c7", load_resp_o, 0);
        check_val("c032_idle_c7", busy_o, 0);

        // Both pending, no hazard: load first, then store.
        do_reset();
        load_req = 1; load_addr = 9'h055; store_req = 1; store_addr = 9'h1F0;
        step();
        check_val("c033_first_we", mem_we_o, 0);
        serve(0, 0, we_seen);
        check_val("c033_lresp", load_resp_o, 1);
        load_req = 0;
        step();
        check_val("c033_second_we", mem_we_o, 1);
        check_val("c033_second_addr", mem_addr_o, 9'h1F0);
        serve(1, 1, we_seen);
        check_val("c033_sresp", store_resp_o, 1);
        store_req = 0;
        step();

        // Hazard forces the store ahead of the load.
        do_reset();
        load_req = 1; load_addr = 9'h0C3; store_req = 1; store_addr = 9'h13C; hazard = 1;
        step();
        check_val("c034_first_we", mem_we_o, 1);
        check_val("c034_first_addr", mem_addr_o, 9'h13C);
        serve(0, 2, we_seen);
        store_req = 0; hazard = 0;
        step();
        check_val("c034_second_we", mem_we_o, 0);
        serve(0, 0, we_seen);
        load_req = 0;
        step();

        // Starvation guard: 4 loads, then the store, twice over.
        do_reset();
        load_req = 1; store_req = 1; load_addr = 9'h010; store_addr = 9'h1A0;
        for (int k = 0; k < 10; k++) begin
            serve($urandom_range(0, 2), $urandom_range(0, 2), we_seen);
            check_val($sformatf("c035_pick%0d", k), we_seen, int'(k == 4 || k == 9));
            load_addr = 9'($urandom);
            store_addr = 9'($urandom);
        end
        load_req = 0; store_req = 0;
        step();

        // Long grant stall, then rvalid while idle sets sticky error.
        do_reset();
        load_req = 1; load_addr = 9'h0AB;
        step();
        for (int k = 0; k < 7; k++) begin
            check_val("c036_req_hold", mem_req_o, 1);
            check_val("c036_addr_hold", mem_addr_o, 9'h0AB);
            step();
        end
        gnt = 1; step(); gnt = 0;
        rvalid = 1; step(); rvalid = 0;
        load_req = 0;
        step();
        check_val("c036_err_before", err_o, 0);
        rvalid = 1; step(); rvalid = 0;
        check_val("c036_err_set", err_o, 1);
        repeat (3) step();
        check_val("c036_err_sticky", err_o, 1);

        // Grant and rvalid together while requesting: grant honoured, error flagged.
        do_reset();
        store_req = 1; store_addr = 9'h077;
        step();
        gnt = 1; rvalid = 1;
        step();
        gnt = 0; rvalid = 0;
        check_val("c026_err", err_o, 1);
        check_val("c026_in_wait", int'(busy_o && !mem_req_o), 1);
        rvalid = 1; step(); rvalid = 0;
        check_val("c026_sresp", store_resp_o, 1);
        store_req = 0;
        step();

        // Reset while waiting for data: transaction dropped, late rvalid errors.
        do_reset();
        load_req = 1; load_addr = 9'h1C1;
        step();
        gnt = 1; step(); gnt = 0;
        check_val("c037_in_wait", busy_o, 1);
        rst = 1; load_req = 0;
        #1;
        check_zero("c037_rst");
        step();
        rst = 0;
        rvalid = 1; step(); rvalid = 0;
        check_val("c037_no_resp", load_resp_o, 0);
        check_val("c037_err", err_o, 1);
        step();

        // Random legal traffic, then random traffic with protocol violations.
        do_reset();
        repeat (1500) rand_cycle(1'b0);
        do_reset();
        repeat (800) rand_cycle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
